bus_slave: RTL and testbench

BUS_SLAVE -- requirements
Module: bus_slave

---
 rtl/bus_slave.sv | 175 +++++++++++++++++
 tb/tb_bus_slave.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave.sv
// Serial-bus memory slave: 16-bit LSB-first address, 4-cycle ACK windows,
// 8-bit LSB-first writes and MSB-first reads of a 2**MEM_AW byte memory.
module bus_slave #(
    parameter logic [15:0] BASE_ADDR = 16'h1000,
    parameter int unsigned MEM_AW    = 8
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic B_UTIL,
    input  logic B_RW,
    input  logic B_BUS_IN,
    output logic B_BUS_OUT,
    output logic B_ACK,
    output logic S_BSY,
    output logic S_WR_STB
);

    localparam int unsigned DEPTH   = 1 << MEM_AW;
    localparam logic [15:0] HI_MASK = 16'hFFFF << MEM_AW;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WDATA,
        WR_ACK,
        RDATA
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        rw_q, rw_d;
    logic        seen_q, seen_d;
    logic        mem_we;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  rd_byte;

    logic        ack_q, ack_d;
    logic        bsy_q, bsy_d;
    logic        wr_stb_q, wr_stb_d;
    logic        bus_out_q, bus_out_d;

    function automatic logic is_hit(input logic [15:0] a);
        return ((a ^ BASE_ADDR) & HI_MASK) == 16'd0;
    endfunction

    assign rd_byte = mem_q[addr_q[MEM_AW-1:0]];

    // State, datapath and output registers; memory is cleared by reset
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 16'd0;
            data_q    <= 8'd0;
            rw_q      <= 1'b0;
            seen_q    <= 1'b0;
            mem_q     <= '{default: 8'h00};
            ack_q     <= 1'b0;
            bsy_q     <= 1'b0;
            wr_stb_q  <= 1'b0;
            bus_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rw_q      <= rw_d;
            seen_q    <= seen_d;
            if (mem_we) begin
                mem_q[addr_q[MEM_AW-1:0]] <= data_q;
            end
            ack_q     <= ack_d;
            bsy_q     <= bsy_d;
            wr_stb_q  <= wr_stb_d;
            bus_out_q <= bus_out_d;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        seen_d  = seen_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (B_UTIL) begin
                    addr_d  = {B_BUS_IN, 15'd0};
                    rw_d    = B_RW;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (!B_UTIL) begin
                    state_d = IDLE;
                end else begin
                    addr_d = {B_BUS_IN, addr_q[15:1]};
                    if (cnt_q == 4'd14) state_d = ADDR_ACK;
                    else                cnt_d   = cnt_q + 4'd1;
                end
            end
            ADDR_ACK: begin
                if (cnt_q == 4'd3) begin
                    if (!is_hit(addr_q)) begin
                        state_d = IDLE;
                    end else if (rw_q) begin
                        state_d = WDATA;
                        seen_d  = 1'b0;
                        data_d  = 8'd0;
                    end else begin
                        state_d = RDATA;
                        data_d  = {rd_byte[6:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WDATA: begin
                // cnt counts wait cycles until the first bit, then bits received
                if (seen_q && cnt_q == 4'd8) begin
                    mem_we  = 1'b1;
                    state_d = WR_ACK;
                end else if (B_UTIL) begin
                    data_d = {B_BUS_IN, data_q[7:1]};
                    seen_d = 1'b1;
                    cnt_d  = seen_q ? cnt_q + 4'd1 : 4'd1;
                end else if (seen_q || cnt_q == 4'd15) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR_ACK: begin
                if (cnt_q == 4'd3) state_d = IDLE;
                else               cnt_d   = cnt_q + 4'd1;
            end
            RDATA: begin
                if (cnt_q == 4'd7) begin
                    state_d = IDLE;
                end else begin
                    data_d = {data_q[6:0], 1'b0};
                    cnt_d  = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = 4'd0;
    end

    // Output values for the next cycle, derived from the next state
    always_comb begin
        ack_d     = 1'b0;
        bsy_d     = 1'b0;
        wr_stb_d  = 1'b0;
        bus_out_d = 1'b0;
        bsy_d     = (state_d != IDLE);
        ack_d     = (state_d == ADDR_ACK && is_hit(addr_d)) || (state_d == WR_ACK);
        wr_stb_d  = (state_d == WDATA) && seen_d && (cnt_d == 4'd8);
        if (state_d == RDATA) begin
            bus_out_d = (state_q == RDATA) ? data_q[7] : rd_byte[7];
        end
    end

    assign B_ACK     = ack_q;
    assign S_BSY     = bsy_q;
    assign S_WR_STB  = wr_stb_q;
    assign B_BUS_OUT = bus_out_q;

endmodule

// File: tb/tb_bus_slave.sv
// Directed plus randomized bench for bus_slave against a byte-array memory model.
module tb_bus_slave;

    logic CLK = 1'b0;
    logic RSTN;
    logic B_UTIL, B_RW, B_BUS_IN;
    logic B_BUS_OUT, B_ACK, S_BSY, S_WR_STB;

    int checks   = 0;
    int failures = 0;
    int stb_cnt  = 0;

    logic [7:0] model_mem [256];

    bus_slave #(.BASE_ADDR(16'h1000), .MEM_AW(8)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .B_UTIL    (B_UTIL),
        .B_RW      (B_RW),
        .B_BUS_IN  (B_BUS_IN),
        .B_BUS_OUT (B_BUS_OUT),
        .B_ACK     (B_ACK),
        .S_BSY     (S_BSY),
        .S_WR_STB  (S_WR_STB)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (S_WR_STB === 1'b1) stb_cnt <= stb_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic in_range(input logic [15:0] a);
        return a[15:8] == 8'h10;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw, input int nbits);
        B_UTIL = 1'b1;
        B_RW   = rw;
        for (int i = 0; i < nbits; i++) begin
            B_BUS_IN = a[i];
            tick();
        end
        B_UTIL   = 1'b0;
        B_BUS_IN = 1'b0;
    endtask

    task automatic ack_window(input string tag, input logic expv);
        for (int c = 0; c < 4; c++) begin
            chk(tag, 16'(B_ACK), 16'(expv));
            chk("bsy_in_ack", 16'(S_BSY), 16'd1);
            tick();
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int waits);
        int stb0;
        logic h;
        stb0 = stb_cnt;
        h = in_range(a);
        send_addr(a, 1'b1, 16);
        ack_window("addr_ack_wr", h);
        if (h) begin
            repeat (waits) tick();
            B_UTIL = 1'b1;
            for (int i = 0; i < 8; i++) begin
                B_BUS_IN = d[i];
                tick();
            end
            B_UTIL = 1'b0;
            chk("wr_stb_commit", 16'(S_WR_STB), 16'd1);
            tick();
            ack_window("wr_ack", 1'b1);
            model_mem[a[7:0]] = d;
        end
        chk("idle_after_wr", 16'(S_BSY), 16'd0);
        chk("ack_idle_wr", 16'(B_ACK), 16'd0);
        chk("stb_count_wr", 16'(stb_cnt - stb0), h ? 16'd1 : 16'd0);
    endtask

    task automatic do_read(input logic [15:0] a);
        logic h;
        logic [7:0] eb;
        h  = in_range(a);
        eb = model_mem[a[7:0]];
        send_addr(a, 1'b0, 16);
        chk("bus_out_in_ack", 16'(B_BUS_OUT), 16'd0);
        ack_window("addr_ack_rd", h);
        if (h) begin
            for (int k = 0; k < 8; k++) begin
                chk("rd_bit", 16'(B_BUS_OUT), 16'(eb[7-k]));
                chk("bsy_rd", 16'(S_BSY), 16'd1);
                tick();
            end
        end
        chk("idle_after_rd", 16'(S_BSY), 16'd0);
        chk("bus_out_idle", 16'(B_BUS_OUT), 16'd0);
    endtask

    task automatic do_addr_abort(input logic [15:0] a, input int nbits);
        send_addr(a, 1'b1, nbits);
        chk("bsy_mid_addr", 16'(S_BSY), 16'd1);
        tick();
        chk("abort_idle", 16'(S_BSY), 16'd0);
        chk("abort_no_ack", 16'(B_ACK), 16'd0);
    endtask

    task automatic do_gap(input logic [15:0] a, input logic [7:0] d, input int nb);
        int stb0;
        stb0 = stb_cnt;
        send_addr(a, 1'b1, 16);
        ack_window("addr_ack_gap", 1'b1);
        B_UTIL = 1'b1;
        for (int i = 0; i < nb; i++) begin
            B_BUS_IN = d[i];
            tick();
        end
        B_UTIL = 1'b0;
        tick();
        chk("gap_idle", 16'(S_BSY), 16'd0);
        chk("gap_no_stb", 16'(stb_cnt - stb0), 16'd0);
    endtask

    task automatic do_timeout(input logic [15:0] a);
        int stb0;
        stb0 = stb_cnt;
        send_addr(a, 1'b1, 16);
        ack_window("addr_ack_to", 1'b1);
        repeat (15) tick();
        chk("wait15_busy", 16'(S_BSY), 16'd1);
        tick();
        chk("timeout_idle", 16'(S_BSY), 16'd0);
        chk("timeout_no_stb", 16'(stb_cnt - stb0), 16'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          op;

        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        RSTN = 1'b1; B_UTIL = 1'b0; B_RW = 1'b0; B_BUS_IN = 1'b0;
        #3 RSTN = 1'b0;
        #1;
        chk("rst_ack", 16'(B_ACK), 16'd0);
        chk("rst_bsy", 16'(S_BSY), 16'd0);
        chk("rst_stb", 16'(S_WR_STB), 16'd0);
        chk("rst_bus_out", 16'(B_BUS_OUT), 16'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTN = 1'b1;
        tick();
        chk("post_rst_idle", 16'(S_BSY), 16'd0);

        // Basic write then read-back
        do_write(16'h1005, 8'hA5, 0);
        do_read(16'h1005);
        // Miss leaves memory untouched
        do_write(16'h2005, 8'h5A, 0);
        do_read(16'h2005);
        do_read(16'h1005);
        // Address abort after bit 9, and at the edges
        do_addr_abort(16'h1005, 10);
        do_addr_abort(16'h1005, 1);
        do_addr_abort(16'h1005, 15);
        // Top and bottom byte of the window
        do_write(16'h10FF, 8'h3C, 3);
        do_write(16'h1000, 8'hC3, 15);
        do_read(16'h10FF);
        do_read(16'h1000);
        // Data-phase aborts
        do_timeout(16'h1000);
        do_read(16'h1000);
        do_gap(16'h10FF, 8'h11, 1);
        do_gap(16'h10FF, 8'h11, 7);
        do_read(16'h10FF);

        // Reset during data bit 4 of a write
        send_addr(16'h1042, 1'b1, 16);
        ack_window("addr_ack_rst", 1'b1);
        B_UTIL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            B_BUS_IN = i[0];
            tick();
        end
        B_BUS_IN = 1'b1;
        #2 RSTN = 1'b0;
        #1;
        B_UTIL = 1'b0;
        chk("midrst_bsy", 16'(S_BSY), 16'd0);
        chk("midrst_ack", 16'(B_ACK), 16'd0);
        chk("midrst_stb", 16'(S_WR_STB), 16'd0);
        chk("midrst_bus_out", 16'(B_BUS_OUT), 16'd0);
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RSTN = 1'b1;
        tick();
        do_read(16'h1042);
        do_read(16'h1005);

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 9) < 8) ? 16'h1000 : 16'($urandom);
            a[7:0] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d  = 8'($urandom);
            op = $urandom_range(0, 9);
            if (op < 4)       do_write(a, d, $urandom_range(0, 15));
            else if (op < 8)  do_read(a);
            else if (op == 8) do_addr_abort(a, $urandom_range(1, 15));
            else if (in_range(a)) do_gap(a, d, $urandom_range(1, 7));
            else              do_read(a);
        end
        for (int i = 0; i < 8; i++) do_read(16'h1000 + 16'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
